mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/mem_ctrl_if.sv | 25 ++
 rtl/mem_bank.sv | 59 +++++
 rtl/mem_ctrl.sv | 115 +++++++++++
 tb/tb_mem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers
// for the data memory controller.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_RESP
    } state_e;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W)
            || (sz == SZ_BU) || (sz == SZ_HU);
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] sz);
        case (sz[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] sz);
        case (sz[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(
        input logic [2:0]  sz,
        input logic [31:0] d
    );
        case (sz)
            SZ_B:    return {{24{d[7]}}, d[7:0]};
            SZ_H:    return {{16{d[15]}}, d[15:0]};
            SZ_BU:   return {24'b0, d[7:0]};
            SZ_HU:   return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between a load/store unit
// and the data memory controller.
interface mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc
    );

endinterface

// File: rtl/mem_bank.sv
// DEPTH_WORDS x 32 synchronous RAM, byte-lane writes,
// registered read; SPRAM pairs when synthesized.
module mem_bank #(
    parameter int    DEPTH_WORDS = 16384,
    parameter int    AW          = $clog2(DEPTH_WORDS),
    parameter string INIT_FILE   = ""
) (
    input  logic          CLK,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

`ifndef SYNTHESIS
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
`else
    localparam int NP = (DEPTH_WORDS + 16383) / 16384;

    logic [31:0] w_a32;
    logic [17:0] r_pidx;
    logic [31:0] w_pout [NP];

    assign w_a32   = 32'(i_addr);
    assign o_rdata = w_pout[r_pidx];

    always_ff @(posedge CLK) r_pidx <= w_a32[31:14];

    for (genvar p = 0; p < NP; p++) begin : g_pair
        logic w_cs;
        assign w_cs = (w_a32[31:14] == 18'(p));
        SB_SPRAM256KA u_lo (
            .ADDRESS(w_a32[13:0]), .DATAIN(i_wdata[15:0]),
            .MASKWREN({i_be[1], i_be[1], i_be[0], i_be[0]}),
            .WREN(|i_be[1:0]), .CHIPSELECT(w_cs), .CLOCK(CLK),
            .STANDBY(1'b0), .SLEEP(1'b0), .POWEROFF(1'b1),
            .DATAOUT(w_pout[p][15:0])
        );
        SB_SPRAM256KA u_hi (
            .ADDRESS(w_a32[13:0]), .DATAIN(i_wdata[31:16]),
            .MASKWREN({i_be[3], i_be[3], i_be[2], i_be[2]}),
            .WREN(|i_be[3:2]), .CHIPSELECT(w_cs), .CLOCK(CLK),
            .STANDBY(1'b0), .SLEEP(1'b0), .POWEROFF(1'b1),
            .DATAOUT(w_pout[p][31:16])
        );
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Data memory controller: B/H/W loads and stores, optional
// two-word split for misaligned accesses, access faults.
module mem_ctrl #(
    parameter int    DEPTH_WORDS = 16384,
    parameter int    MISALIGN_EN = 1,
    parameter string INIT_FILE   = ""
) (
    input logic       CLK,
    input logic       RST,
    mem_ctrl_if.slave bus
);
    import mem_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        r_state, w_next;
    logic [AW-1:0] r_word;
    logic [1:0]    r_off;
    logic [2:0]    r_size;
    logic          r_wr, r_exc, r_split;
    logic [3:0]    r_be_hi;
    logic [31:0]   r_wd_hi, r_lo;

    logic          w_acc, w_mis, w_cross, w_oor, w_exc, w_split;
    logic [30:0]   w_last_w;
    logic [7:0]    w_be8;
    logic [63:0]   w_wd64;
    logic [AW-1:0] w_ram_addr;
    logic [3:0]    w_ram_be;
    logic [31:0]   w_ram_wd, w_ram_rd, w_lo, w_shift;

    assign bus.req_ready = (r_state == ST_IDLE) && !RST;
    assign w_acc = bus.req_valid && bus.req_ready;

    assign w_mis = (bus.req_size[1:0] == 2'b01 && bus.req_addr[0])
                || (bus.req_size[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign w_cross = ({1'b0, bus.req_addr[1:0]}
                   + size_bytes(bus.req_size)) > 3'd4;

    // Index of the word holding the last touched byte; no wrap-around.
    assign w_last_w = {1'b0, bus.req_addr[31:2]} + {30'b0, w_cross};
    assign w_oor    = |w_last_w[30:AW];

    assign w_exc = !size_legal(bus.req_size)
                || (bus.req_wr && bus.req_size[2])
                || (MISALIGN_EN == 0 && w_mis)
                || w_oor;
    assign w_split = w_cross && !w_exc;

    assign w_be8  = {4'b0, size_mask(bus.req_size)} << bus.req_addr[1:0];
    assign w_wd64 = {32'b0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};

    always_comb begin
        w_ram_addr = r_word + 1'b1;
        w_ram_be   = 4'b0;
        w_ram_wd   = r_wd_hi;
        if (w_acc) begin
            w_ram_addr = bus.req_addr[AW+1:2];
            w_ram_be   = (bus.req_wr && !w_exc) ? w_be8[3:0] : 4'b0;
            w_ram_wd   = w_wd64[31:0];
        end else if (r_state == ST_SPLIT && r_wr && !RST) begin
            w_ram_be = r_be_hi;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_acc) w_next = w_split ? ST_SPLIT : ST_RESP;
            ST_SPLIT: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge CLK) begin
        if (w_acc) begin
            r_word  <= bus.req_addr[AW+1:2];
            r_off   <= bus.req_addr[1:0];
            r_size  <= bus.req_size;
            r_wr    <= bus.req_wr;
            r_exc   <= w_exc;
            r_split <= w_split;
            r_be_hi <= w_be8[7:4];
            r_wd_hi <= w_wd64[63:32];
        end
        if (r_state == ST_SPLIT) r_lo <= w_ram_rd;
    end

    mem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW),
        .INIT_FILE  (INIT_FILE)
    ) u_bank (
        .CLK    (CLK),
        .i_addr (w_ram_addr),
        .i_be   (w_ram_be),
        .i_wdata(w_ram_wd),
        .o_rdata(w_ram_rd)
    );

    assign w_lo    = r_split ? r_lo : w_ram_rd;
    assign w_shift = 32'({w_ram_rd, w_lo} >> {r_off, 3'b000});

    assign bus.rsp_valid = (r_state == ST_RESP) && !RST;
    assign bus.rsp_exc   = bus.rsp_valid && r_exc;
    assign bus.rsp_rdata = (bus.rsp_valid && !r_exc && !r_wr)
                         ? load_ext(r_size, w_shift) : 32'b0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: one instance with splitting, one without,
// both 16 words deep, against a byte-array reference model.
module tb_mem_ctrl;
    import mem_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_ctrl_if b0 ();
    mem_ctrl_if b1 ();

    logic        sel, t_valid, t_wr;
    logic [2:0]  t_size;
    logic [31:0] t_addr, t_wdata;
    logic        w_ready, w_rvalid, w_rexc;
    logic [31:0] w_rdata;

    assign b0.req_valid = t_valid && !sel;
    assign b1.req_valid = t_valid && sel;
    assign b0.req_wr    = t_wr;
    assign b1.req_wr    = t_wr;
    assign b0.req_size  = t_size;
    assign b1.req_size  = t_size;
    assign b0.req_addr  = t_addr;
    assign b1.req_addr  = t_addr;
    assign b0.req_wdata = t_wdata;
    assign b1.req_wdata = t_wdata;

    assign w_ready  = sel ? b1.req_ready : b0.req_ready;
    assign w_rvalid = sel ? b1.rsp_valid : b0.rsp_valid;
    assign w_rexc   = sel ? b1.rsp_exc   : b0.rsp_exc;
    assign w_rdata  = sel ? b1.rsp_rdata : b0.rsp_rdata;

    mem_ctrl #(
        .DEPTH_WORDS(16), .MISALIGN_EN(0), .INIT_FILE("")
    ) u_dut0 (.CLK(CLK), .RST(RST), .bus(b0));

    mem_ctrl #(
        .DEPTH_WORDS(16), .MISALIGN_EN(1), .INIT_FILE("")
    ) u_dut1 (.CLK(CLK), .RST(RST), .bus(b1));

    int errors = 0;
    int checks = 0;

    // Byte-addressed image of each instance (index 0 = no split).
    logic [7:0] mem [2][64];

    typedef struct {
        logic        s;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic        ex;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic s, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input int lat,
                                input logic [31:0] rd, input logic ex);
        vec_t v;
        v.s = s; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
        v.lat = lat; v.rd = rd; v.ex = ex;
        vt.push_back(v);
    endfunction

    function automatic void model(input logic s, input logic wr,
                                  input logic [2:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, input logic first_only,
                                  output int lat, output logic [31:0] rd,
                                  output logic ex);
        int n;
        int idx;
        logic [63:0] last;
        logic [31:0] v;
        n = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
        ex = !(sz inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (wr && sz[2]) ex = 1'b1;
        if (!s && (a % n) != 0) ex = 1'b1;
        last = {32'b0, a} + 64'(n) - 64'd1;
        if (last >= 64) ex = 1'b1;
        lat = 1;
        rd = 32'b0;
        v = 32'b0;
        if (ex) return;
        if (int'(a % 4) + n > 4) lat = 2;
        for (int i = 0; i < n; i++) begin
            idx = int'(a) + i;
            if (wr) begin
                if (!first_only || (idx / 4) == (int'(a) / 4))
                    mem[s][idx] = wd[8*i +: 8];
            end else begin
                v[8*i +: 8] = mem[s][idx];
            end
        end
        if (!wr) begin
            case (sz)
                3'b000:  rd = v[7]  ? (v | 32'hFFFF_FF00) : v;
                3'b001:  rd = v[15] ? (v | 32'hFFFF_0000) : v;
                default: rd = v;
            endcase
        end
    endfunction

    task automatic chk(input string nm, input int lat, input logic [31:0] rd,
                       input logic ex, input int elat, input logic [31:0] erd,
                       input logic eex);
        checks++;
        if (lat !== elat || rd !== erd || ex !== eex) begin
            errors++;
            $display("FAIL %s: got lat=%0d rdata=%08h exc=%0b, want lat=%0d rdata=%08h exc=%0b",
                     nm, lat, rd, ex, elat, erd, eex);
        end
    endtask

    task automatic chk_v(input string nm, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    // Starts at a negedge, ends at the negedge after the response.
    // lat counts cycles after accept; +100 flags stray or stretched outputs.
    task automatic xact(input logic s, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic ex);
        int n;
        logic stray;
        lat = 0; rd = 32'b0; ex = 1'b0; stray = 1'b0; n = 0;
        sel = s; t_wr = wr; t_size = sz; t_addr = a; t_wdata = wd;
        t_valid = 1'b1;
        #1;
        while (!w_ready && n < 8) begin
            @(negedge CLK);
            n++;
        end
        if (!w_ready) begin
            t_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        t_valid = 1'b0;
        for (int c = 1; c <= 4 && lat == 0; c++) begin
            if (w_rvalid) begin
                lat = c; rd = w_rdata; ex = w_rexc;
            end else begin
                if (w_rexc || w_rdata != 32'b0) stray = 1'b1;
                @(negedge CLK);
            end
        end
        if (lat == 0) begin
            lat = -1;
        end else begin
            @(negedge CLK);
            if (w_rvalid) stray = 1'b1;
        end
        if (stray) lat += 100;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, mlat;
        logic [31:0] rd, mrd, a;
        logic ex, mex, seen, wr;
        logic [2:0] sz;
        logic [2:0] szt [10];

        szt = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU, SZ_B, SZ_H, SZ_W, 3'b011, 3'b110};
        sel = 1'b0; t_valid = 1'b1; t_wr = 1'b1; t_size = SZ_W;
        t_addr = 32'h0; t_wdata = 32'hFFFF_FFFF;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) mem[s][i] = 8'h00;

        repeat (3) @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk_v($sformatf("rst_ready%0d", s), 64'(w_ready), 64'd0);
            chk_v($sformatf("rst_rsp%0d", s), {w_rvalid, w_rexc, w_rdata}, 64'd0);
        end
        t_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk_v($sformatf("ready_after_rst%0d", s), 64'(w_ready), 64'd1);
        end

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                model(s[0], 1'b1, SZ_W, 32'(w * 4), 32'h0, 1'b0, mlat, mrd, mex);
                xact(s[0], 1'b1, SZ_W, 32'(w * 4), 32'h0, lat, rd, ex);
                chk($sformatf("init%0d_%0d", s, w), lat, rd, ex, mlat, mrd, mex);
            end
        end

        add(1, 1, SZ_W,   32'h10, 32'hDEADBEEF, 1, 32'h0,        0);
        add(1, 0, SZ_W,   32'h10, 32'h0,        1, 32'hDEADBEEF, 0);
        add(1, 1, SZ_W,   32'h10, 32'h0,        1, 32'h0,        0);
        add(1, 1, SZ_B,   32'h13, 32'h5A5A5A80, 1, 32'h0,        0);
        add(1, 0, SZ_B,   32'h13, 32'h0,        1, 32'hFFFFFF80, 0);
        add(1, 0, SZ_BU,  32'h13, 32'h0,        1, 32'h00000080, 0);
        add(1, 0, SZ_W,   32'h10, 32'h0,        1, 32'h80000000, 0);
        add(1, 1, SZ_W,   32'h0E, 32'h11223344, 2, 32'h0,        0);
        add(1, 0, SZ_W,   32'h0E, 32'h0,        2, 32'h11223344, 0);
        add(1, 0, SZ_W,   32'h0C, 32'h0,        1, 32'h33440000, 0);
        add(1, 0, SZ_W,   32'h10, 32'h0,        1, 32'h80001122, 0);
        add(1, 0, SZ_H,   32'h0F, 32'h0,        2, 32'h00002233, 0);
        add(1, 0, SZ_HU,  32'h0D, 32'h0,        1, 32'h00004400, 0);
        add(1, 0, SZ_H,   32'h0E, 32'h0,        1, 32'h00003344, 0);
        add(1, 1, SZ_H,   32'h11, 32'h0000BEEF, 1, 32'h0,        0);
        add(1, 0, SZ_W,   32'h10, 32'h0,        1, 32'h80BEEF22, 0);
        add(1, 0, SZ_W,   32'h3E, 32'h0,        1, 32'h0,        1);
        add(1, 1, SZ_W,   32'h40, 32'h12345678, 1, 32'h0,        1);
        add(1, 0, SZ_W,   32'h00, 32'h0,        1, 32'h0,        0);
        add(1, 0, 3'b011, 32'h00, 32'h0,        1, 32'h0,        1);
        add(1, 1, SZ_BU,  32'h00, 32'hFF,       1, 32'h0,        1);
        add(1, 0, 3'b110, 32'h00, 32'h0,        1, 32'h0,        1);
        add(1, 1, 3'b111, 32'h00, 32'h0,        1, 32'h0,        1);
        add(1, 0, SZ_HU,  32'h3F, 32'h0,        1, 32'h0,        1);
        add(1, 1, SZ_W,   32'h3C, 32'hCAFEBABE, 1, 32'h0,        0);
        add(1, 0, SZ_B,   32'h3F, 32'h0,        1, 32'hFFFFFFCA, 0);
        add(1, 0, SZ_W,   32'hFFFFFFFE, 32'h0,  1, 32'h0,        1);
        add(0, 1, SZ_W,   32'h00, 32'hA5A5A5A5, 1, 32'h0,        0);
        add(0, 0, SZ_H,   32'h01, 32'h0,        1, 32'h0,        1);
        add(0, 1, SZ_W,   32'h02, 32'hFFFFFFFF, 1, 32'h0,        1);
        add(0, 0, SZ_W,   32'h00, 32'h0,        1, 32'hA5A5A5A5, 0);
        add(0, 0, SZ_H,   32'h02, 32'h0,        1, 32'hFFFFA5A5, 0);
        add(0, 0, SZ_HU,  32'h02, 32'h0,        1, 32'h0000A5A5, 0);
        add(0, 0, SZ_B,   32'h01, 32'h0,        1, 32'hFFFFFFA5, 0);
        add(0, 0, SZ_W,   32'h0E, 32'h0,        1, 32'h0,        1);
        add(0, 0, SZ_B,   32'h0F, 32'h0,        1, 32'h0,        0);

        foreach (vt[i]) begin
            model(vt[i].s, vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd, 1'b0,
                  mlat, mrd, mex);
            xact(vt[i].s, vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd, lat, rd, ex);
            chk($sformatf("vec%0d", i), lat, rd, ex, vt[i].lat, vt[i].rd, vt[i].ex);
        end

        // Reset lands in the second half of a split store.
        @(negedge CLK);
        sel = 1'b1; t_wr = 1'b1; t_size = SZ_W;
        t_addr = 32'h0E; t_wdata = 32'hCAFEF00D; t_valid = 1'b1;
        #1;
        chk_v("abort_accept_ready", 64'(w_ready), 64'd1);
        @(negedge CLK);
        t_valid = 1'b0;
        #1;
        chk_v("split_ready_low", 64'(w_ready), 64'd0);
        RST = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            #1;
            seen |= w_rvalid;
        end
        RST = 1'b0;
        @(negedge CLK);
        #1;
        seen |= w_rvalid;
        chk_v("abort_no_rsp", 64'(seen), 64'd0);
        chk_v("abort_ready", 64'(w_ready), 64'd1);
        model(1'b1, 1'b1, SZ_W, 32'h0E, 32'hCAFEF00D, 1'b1, mlat, mrd, mex);
        model(1'b1, 1'b0, SZ_W, 32'h0C, 32'h0, 1'b0, mlat, mrd, mex);
        xact(1'b1, 1'b0, SZ_W, 32'h0C, 32'h0, lat, rd, ex);
        chk("abort_word0C", lat, rd, ex, mlat, mrd, mex);
        chk_v("abort_word0C_val", 64'(rd), 64'hF00D0000);
        model(1'b1, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, mlat, mrd, mex);
        xact(1'b1, 1'b0, SZ_W, 32'h10, 32'h0, lat, rd, ex);
        chk("abort_word10", lat, rd, ex, mlat, mrd, mex);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            sz = (r == 9) ? 3'($urandom_range(6, 7)) : szt[r];
            r = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'hFFFF_FFFE;
            else             a = 32'($urandom_range(0, 71));
            wr = 1'($urandom_range(0, 1));
            rd = $urandom;
            model(1'(k % 2), wr, sz, a, rd, 1'b0, mlat, mrd, mex);
            xact(1'(k % 2), wr, sz, a, rd, lat, rd, ex);
            chk($sformatf("rand%0d", k), lat, rd, ex, mlat, mrd, mex);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
